// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 receiver with byte buffer.
// Optional FIFO buffer selected by macro PS2_RX_FIFO_EN (see ps2_rx_buf).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned FILTER_LEN_DEF  = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 50000;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;

  // PS/2 uses odd parity over data plus parity bit.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_buf.sv
// Received-byte buffer: FIFO_DEPTH-entry show-ahead FIFO when PS2_RX_FIFO_EN
// is defined, otherwise a single holding register.
module ps2_rx_buf
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 valid,
  output logic                 overrun
);

`ifdef PS2_RX_FIFO_EN
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 full, empty, pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign valid   = ~empty;
  assign overrun = push & full & ~pop_ok;
`else
  // DEPTH has no effect on the holding register; the guard only consumes it.
  if (DEPTH > 0) begin : g_hold
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 valid_q, valid_d;
    logic                 pop_ok, push_ok;

    assign pop_ok  = pop & valid_q;
    assign push_ok = push & (~valid_q | pop_ok);

    always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      if (pop_ok) valid_d = 1'b0;
      if (push_ok) begin
        hold_d  = wr_data;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        valid_q <= valid_d;
      end
    end

    assign rd_data = valid_q ? hold_q : '0;
    assign valid   = valid_q;
    assign overrun = push & valid_q & ~pop_ok;
  end
`endif

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronizer, glitch filter, frame FSM with
// timeout, feeding ps2_rx_buf (FIFO when PS2_RX_FIFO_EN is defined).
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 SCL,
  input  logic                 SDA,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  logic [1:0]           scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                 scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic                 scl_prev_q, scl_prev_d;
  logic [FW-1:0]        scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  ps2_state_e           state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 scl_fall, tmo_hit, push;

  // Filtered level follows the synced line only after FILTER_LEN differing samples.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], SCL};
    sda_sync_d = {sda_sync_q[0], SDA};
    scl_prev_d = scl_filt_q;
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    scl_cnt_d  = '0;
    sda_cnt_d  = '0;
    if (scl_sync_q[1] != scl_filt_q) begin
      if (scl_cnt_q == FW'(FILTER_LEN - 1)) scl_filt_d = scl_sync_q[1];
      else scl_cnt_d = scl_cnt_q + 1'b1;
    end
    if (sda_sync_q[1] != sda_filt_q) begin
      if (sda_cnt_q == FW'(FILTER_LEN - 1)) sda_filt_d = sda_sync_q[1];
      else sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  assign scl_fall = scl_prev_q & ~scl_filt_q;
  assign tmo_hit  = (state_q != IDLE) & ~scl_fall & (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_prev_q <= scl_prev_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (state_q != IDLE && !scl_fall) begin
      tmo_d = tmo_q + 1'b1;
    end
    if (scl_fall) begin
      unique case (state_q)
        IDLE: begin
          if (!sda_filt_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {sda_filt_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = sda_filt_q;
          state_d = STOP;
        end
        STOP: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push       = 1'b0;
    parity_err = 1'b0;
    frame_err  = tmo_hit;
    busy       = (state_q != IDLE);
    if (scl_fall && state_q == STOP) begin
      if (!odd_parity_ok(shift_q, par_q)) parity_err = 1'b1;
      else if (!sda_filt_q)               frame_err  = 1'b1;
      else                                push       = 1'b1;
    end
  end

  ps2_rx_buf #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (RST),
    .push    (push),
    .wr_data (shift_q),
    .pop     (rd_en),
    .rd_data (data_out),
    .valid   (data_valid),
    .overrun (overrun)
  );

endmodule
